mux_4to1_rr_arbiter: RTL and testbench



---
 rtl/mux_4to1_rr_arbiter_pkg.sv | 13 +
 rtl/mux_4to1_rr_arbiter_mux.sv | 25 ++
 rtl/mux_4to1_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4:1 mux.
// Holds the requester count and the arbiter state encoding.
package mux_4to1_rr_arbiter_pkg;

   localparam int N_REQ = 4;

   // One-hot encoding gives the all-zero and all-one patterns a defined recovery path to idle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_GRANT = 2'b10
   } state_e;

endpackage : mux_4to1_rr_arbiter_pkg

// File: rtl/mux_4to1_rr_arbiter_mux.sv
// Gate-level 4:1 single-bit multiplexer shared by the arbiter's requesters.
// out = in[sel], built from inverters, AND terms and a final OR.
module mux_4to1_structural
   import mux_4to1_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] in,
   input  logic [1:0]       sel,
   output logic             out
);

   logic       sel0_n;
   logic       sel1_n;
   logic [3:0] term;

   not u_inv0 (sel0_n, sel[0]);
   not u_inv1 (sel1_n, sel[1]);

   and u_and0 (term[0], in[0], sel1_n, sel0_n);
   and u_and1 (term[1], in[1], sel1_n, sel[0]);
   and u_and2 (term[2], in[2], sel[1], sel0_n);
   and u_and3 (term[3], in[3], sel[1], sel[0]);

   or  u_or   (out, term[0], term[1], term[2], term[3]);

endmodule : mux_4to1_structural

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a bounded
// hold time while others wait; the mux output is gated by the registered busy flag.
module mux_4to1_rr_arbiter
   import mux_4to1_rr_arbiter_pkg::*;
#(
   parameter  int MAX_HOLD = 8,
   localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] in,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       sel,
   output logic             busy,
   output logic             out
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   state_e             state_q,    state_d;
   logic [N_REQ-1:0]   gnt_q,      gnt_d;
   logic [1:0]         sel_q,      sel_d;
   logic               busy_q,     busy_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [1:0]         ptr_q,      ptr_d;

   logic [N_REQ-1:0]   others;
   logic [2:0]         pick_new;
   logic [2:0]         pick_other;
   logic               mux_out;

   // Returns {found, index} of the first set candidate in order start, start+1, ...
   // Walking from the far end lets the closest hit overwrite later ones.
   function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] cand,
                                          input logic [1:0]       start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = start + 2'(i);
         if (cand[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign others     = req & ~gnt_q;
   assign pick_new   = rr_pick(req, ptr_q);
   assign pick_other = rr_pick(others, ptr_q);

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      hold_cnt_d = hold_cnt_q;
      ptr_d      = ptr_q;

      case (state_q)
         ST_IDLE: begin
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
            if (pick_new[2]) begin
               state_d    = ST_GRANT;
               gnt_d      = N_REQ'(1) << pick_new[1:0];
               sel_d      = pick_new[1:0];
               busy_d     = 1'b1;
               hold_cnt_d = CNT_W'(1);
               ptr_d      = pick_new[1:0] + 2'd1;
            end
         end

         ST_GRANT: begin
            if (!req[sel_q]) begin
               state_d    = ST_IDLE;
               gnt_d      = '0;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_MAX && pick_other[2]) begin
               // ptr already sits one past the owner, so the owner is naturally searched last.
               gnt_d      = N_REQ'(1) << pick_other[1:0];
               sel_d      = pick_other[1:0];
               hold_cnt_d = CNT_W'(1);
               ptr_d      = pick_other[1:0] + 2'd1;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         sel_q      <= 2'd0;
         busy_q     <= 1'b0;
         hold_cnt_q <= '0;
         ptr_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         hold_cnt_q <= hold_cnt_d;
         ptr_q      <= ptr_d;
      end
   end

   mux_4to1_structural u_mux (
      .in  (in),
      .sel (sel_q),
      .out (mux_out)
   );

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;
   assign out  = busy_q & mux_out;

endmodule : mux_4to1_rr_arbiter

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench for the round-robin arbiter: a cycle model pushes expected
// outputs when stimulus is applied, and they are popped after each clock edge.
module tb_mux_4to1_rr_arbiter;

   localparam int MAX_HOLD = 3;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       out;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'h0;
   logic [3:0] din = 4'h0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       dout;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state: owner is -1 while idle.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_sel   = 0;

   always #5 clk = ~clk;

   mux_4to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .in    (din),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy),
      .out   (dout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // First requester at or after 'from' (mod 4) with bit set in r, -1 if none.
   function automatic int search(input logic [3:0] r, input int from);
      for (int j = 0; j < 4; j++) begin
         if (r[(from + j) % 4]) return (from + j) % 4;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic r_n, input logic [3:0] r);
      int nxt;
      if (!r_n) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      end else if (m_owner < 0) begin
         nxt = search(r, m_ptr);
         if (nxt >= 0) begin
            m_owner = nxt; m_sel = nxt; m_hold = 1; m_ptr = (nxt + 1) % 4;
         end
      end else if (!r[m_owner]) begin
         m_owner = -1; m_hold = 0;
      end else if (m_hold == MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'h0) begin
         nxt = search(r & ~(4'b0001 << m_owner), m_ptr);
         m_owner = nxt; m_sel = nxt; m_hold = 1; m_ptr = (nxt + 1) % 4;
      end else if (m_hold < MAX_HOLD) begin
         m_hold++;
      end
   endtask

   // Apply inputs, push the model's prediction, clock once, pop and compare.
   task automatic step(input logic r_n, input logic [3:0] r, input logic [3:0] d);
      exp_t e;
      exp_t got;
      rst_n = r_n;
      req   = r;
      din   = d;
      model_edge(r_n, r);
      e.gnt  = (m_owner < 0) ? 4'h0 : (4'b0001 << m_owner);
      e.sel  = 2'(m_sel);
      e.busy = (m_owner >= 0);
      e.out  = e.busy & d[m_sel];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = '{gnt: gnt, sel: sel, busy: busy, out: dout};
      e = exp_q.pop_front();
      check("gnt",  32'(got.gnt),  32'(e.gnt));
      check("sel",  32'(got.sel),  32'(e.sel));
      check("busy", 32'(got.busy), 32'(e.busy));
      check("out",  32'(got.out),  32'(e.out));
   endtask

   initial begin
      int order_exp[5] = '{0, 1, 2, 3, 0};
      int n_grants;
      logic prev_busy;
      logic [3:0] r;

      // Reset held with all requests pending, then idle release.
      step(1'b0, 4'hF, 4'hF);
      step(1'b0, 4'hF, 4'hF);
      step(1'b1, 4'h0, 4'hF);
      step(1'b1, 4'h0, 4'hF);

      // Single request, one-cycle latency, data routed and gated.
      step(1'b1, 4'b0100, 4'b0000);
      check("single_gnt", 32'(gnt), 32'(4'b0100));
      step(1'b1, 4'b0100, 4'b0100);
      din = 4'b1011;
      #1;
      check("comb_out_low", 32'(dout), 32'(1'b0));
      din = 4'b0100;
      #1;
      check("comb_out_high", 32'(dout), 32'(1'b1));
      step(1'b1, 4'b0000, 4'b0100);

      // Rotation: each owner drops its request after two granted cycles.
      step(1'b0, 4'h0, 4'h0);
      n_grants  = 0;
      prev_busy = 1'b0;
      for (int c = 0; c < 16; c++) begin
         r = 4'hF;
         if (m_owner >= 0 && m_hold >= 2) r = 4'hF & ~(4'b0001 << m_owner);
         step(1'b1, r, 4'b0101);
         if (busy === 1'b1 && prev_busy !== 1'b1 && n_grants < 5) begin
            check("rr_order", 32'(sel), 32'(order_exp[n_grants]));
            n_grants++;
         end
         prev_busy = busy;
      end
      check("rr_grant_count", 32'(n_grants), 32'd5);

      // Hold limit: requester 1 owns, requester 3 waits, switch with no bubble.
      step(1'b0, 4'h0, 4'h0);
      step(1'b1, 4'b0010, 4'b1010);
      step(1'b1, 4'b1010, 4'b1010);
      step(1'b1, 4'b1010, 4'b1010);
      check("hold_still_1", 32'(gnt), 32'(4'b0010));
      step(1'b1, 4'b1010, 4'b1010);
      check("preempt_gnt", 32'(gnt), 32'(4'b1000));
      check("preempt_busy", 32'(busy), 32'(1'b1));
      step(1'b1, 4'b1010, 4'b1010);

      // Wrap from ptr=3 to requester 0, then a lone owner keeps the grant.
      step(1'b0, 4'h0, 4'h0);
      step(1'b1, 4'b0100, 4'h0);
      step(1'b1, 4'b0000, 4'h0);
      for (int c = 0; c < 25; c++) step(1'b1, 4'b0001, 4'(c));
      check("lone_gnt", 32'(gnt), 32'(4'b0001));
      check("lone_hold_sat", 32'(dut.hold_cnt_q), 32'(MAX_HOLD));

      // Reset mid-grant drops the grant at once and restores ptr to 0.
      step(1'b1, 4'b0000, 4'h0);
      step(1'b1, 4'b0100, 4'h0);
      step(1'b1, 4'b0100, 4'h4);
      step(1'b0, 4'b0100, 4'h4);
      check("rst_mid_busy", 32'(busy), 32'(1'b0));
      step(1'b1, 4'b0101, 4'h1);
      check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
      step(1'b1, 4'b0101, 4'h1);

      if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mux_4to1_rr_arbiter
